aes_inv_mixcol_serial: RTL and testbench

Byte-serial, handshaked InvMixColumns engine for the AES decryption datapath. It accepts one 4-byte state column, row 0 first, and returns the transformed column, also row 0 first. Each output byte is the GF(2^8) combination 0e·a_i ^ 0b·a_{i+1} ^ 0d·a_{i+2} ^ 09·a_{i+3}, with indices taken mod 4. The block sits between the InvShiftRows/InvSubBytes byte stream and AddRoundKey in the byte-serial decryption round. Parameter INVERSE=0 turns the same engine into forward MixColumns (02·a_i ^ 03·a_{i+1} ^ a_{i+2} ^ a_{i+3}) for encryption-side reuse.

---
 rtl/aes_inv_mixcol_serial_if.sv | 21 ++
 rtl/aes_inv_mixcol_serial.sv | 128 ++++++++++++
 tb/tb_aes_inv_mixcol_serial.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_mixcol_serial_if.sv
// Byte-serial column handshake bundle for the (Inv)MixColumns engine.
// master = upstream/downstream driver, slave = the engine.
interface aes_inv_mixcol_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/aes_inv_mixcol_serial.sv
// Byte-serial AES InvMixColumns (INVERSE=1) or MixColumns (INVERSE=0) engine.
// Loads a 4-byte column row 0 first, then emits the transformed column row 0 first.
module aes_inv_mixcol_serial #(
    parameter bit INVERSE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    aes_inv_mixcol_serial_if.slave      bus
);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [7:0] col [4];
    logic       in_ready_q;
    logic       out_valid_q;
    logic       out_last_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // col[0] always holds the row being emitted because col rotates after each output.
    function automatic logic [7:0] mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] r;
        if (INVERSE)
            r = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
        else
            r = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            cnt         <= 2'd0;
            col[0]      <= 8'h00;
            col[1]      <= 8'h00;
            col[2]      <= 8'h00;
            col[3]      <= 8'h00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (clr) begin
            state       <= LOAD;
            cnt         <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        col[cnt] <= bus.in_byte;
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state       <= EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        col[0] <= col[1];
                        col[1] <= col[2];
                        col[2] <= col[3];
                        col[3] <= col[0];
                        cnt    <= cnt + 2'd1;
                        // out_last tracks the cnt value that will be current next cycle
                        out_last_q <= (cnt == 2'd2);
                        if (cnt == 2'd3) begin
                            state       <= LOAD;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_byte  = mix_byte(col[0], col[1], col[2], col[3]);

endmodule

// File: tb/tb_aes_inv_mixcol_serial.sv
// Directed bench for aes_inv_mixcol_serial: one inverse and one forward instance
// share the same stimulus; the selected instance's outputs are checked.
module tb_aes_inv_mixcol_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       out_ready = 1'b0;
    logic       sel_fwd = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_inv_mixcol_serial_if bus_inv ();
    aes_inv_mixcol_serial_if bus_fwd ();

    assign bus_inv.in_valid  = in_valid;
    assign bus_inv.in_byte   = in_byte;
    assign bus_inv.out_ready = out_ready;
    assign bus_fwd.in_valid  = in_valid;
    assign bus_fwd.in_byte   = in_byte;
    assign bus_fwd.out_ready = out_ready;

    aes_inv_mixcol_serial #(.INVERSE(1'b1)) dut_inv (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus_inv)
    );

    aes_inv_mixcol_serial #(.INVERSE(1'b0)) dut_fwd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus_fwd)
    );

    logic       cur_in_ready, cur_out_valid, cur_out_last;
    logic [7:0] cur_out_byte;
    assign cur_in_ready  = sel_fwd ? bus_fwd.in_ready  : bus_inv.in_ready;
    assign cur_out_valid = sel_fwd ? bus_fwd.out_valid : bus_inv.out_valid;
    assign cur_out_last  = sel_fwd ? bus_fwd.out_last  : bus_inv.out_last;
    assign cur_out_byte  = sel_fwd ? bus_fwd.out_byte  : bus_inv.out_byte;

    typedef struct {
        bit          fwd;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        int n;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (g) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("in_handshake");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input bit last, input int max_stall);
        int s;
        int n;
        n = 0;
        while (!cur_out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("out_handshake");
        s = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
        for (int k = 0; k < s; k++) begin
            check("stall_byte", cur_out_byte, exp);
            check("stall_last", {7'd0, cur_out_last}, {7'd0, last});
            check("emit_in_ready", {7'd0, cur_in_ready}, 8'h00);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("out_byte", cur_out_byte, exp);
        check("out_last", {7'd0, cur_out_last}, {7'd0, last});
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic send_col(input logic [31:0] d, input int max_gap);
        for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8], max_gap);
    endtask

    task automatic recv_col(input logic [31:0] d, input int max_stall);
        for (int i = 0; i < 4; i++) recv_byte(d[31-8*i -: 8], (i == 3), max_stall);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 32'h8e4da1bc, 32'hdb135345};
        vecs[1] = '{1'b1, 32'hdb135345, 32'h8e4da1bc};
        vecs[2] = '{1'b1, 32'hd4d4d4d5, 32'hd5d5d7d6};
        vecs[3] = '{1'b1, 32'hc6c6c6c6, 32'hc6c6c6c6};
        vecs[4] = '{1'b0, 32'hd5d5d7d6, 32'hd4d4d4d5};
        vecs[5] = '{1'b0, 32'hc6c6c6c6, 32'hc6c6c6c6};
        vecs[6] = '{1'b0, 32'h9fdc589d, 32'hf20a225c};
        vecs[7] = '{1'b1, 32'hf20a225c, 32'h9fdc589d};

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_in_ready", {7'd0, cur_in_ready}, 8'h01);
        check("rst_out_valid", {7'd0, cur_out_valid}, 8'h00);
        check("rst_out_last", {7'd0, cur_out_last}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_in_ready", {7'd0, cur_in_ready}, 8'h01);
            check("idle_out_valid", {7'd0, cur_out_valid}, 8'h00);
            check("idle_out_byte", cur_out_byte, 8'h00);
        end

        // Known-answer table, continuous handshakes
        for (int v = 0; v < 8; v++) begin
            sel_fwd = vecs[v].fwd;
            for (int i = 0; i < 3; i++) send_byte(vecs[v].din[31-8*i -: 8], 0);
            check("pre_latency_valid", {7'd0, cur_out_valid}, 8'h00);
            send_byte(vecs[v].din[7:0], 0);
            check("latency_valid", {7'd0, cur_out_valid}, 8'h01);
            check("latency_in_ready", {7'd0, cur_in_ready}, 8'h00);
            recv_col(vecs[v].dout, 0);
            check("post_col_in_ready", {7'd0, cur_in_ready}, 8'h01);
        end

        // Random gaps and stalls on the inverse engine
        sel_fwd = 1'b0;
        for (int r = 0; r < 3; r++) begin
            send_col(32'h9fdc589d, 3);
            recv_col(32'hf20a225c, 4);
        end

        // clr during LOAD with in_valid high: the byte must be dropped
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        in_valid = 1'b1;
        in_byte  = 8'h44;
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_load_in_ready", {7'd0, cur_in_ready}, 8'h01);
        check("clr_load_out_valid", {7'd0, cur_out_valid}, 8'h00);
        send_col(32'h8e4da1bc, 0);
        recv_col(32'hdb135345, 0);

        // clr after two output bytes
        send_col(32'h8e4da1bc, 0);
        recv_byte(8'hdb, 1'b0, 0);
        recv_byte(8'h13, 1'b0, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("clr_emit_out_valid", {7'd0, cur_out_valid}, 8'h00);
            check("clr_emit_in_ready", {7'd0, cur_in_ready}, 8'h01);
            @(negedge clk);
        end
        out_ready = 1'b0;
        send_col(32'h9fdc589d, 1);
        recv_col(32'hf20a225c, 1);

        // Asynchronous reset in the middle of EMIT
        send_col(32'h8e4da1bc, 0);
        check("pre_rst_valid", {7'd0, cur_out_valid}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", {7'd0, cur_out_valid}, 8'h00);
        check("async_in_ready", {7'd0, cur_in_ready}, 8'h01);
        check("async_out_byte", cur_out_byte, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send_col(32'h8e4da1bc, 0);
        recv_col(32'hdb135345, 0);
        send_col(32'h9fdc589d, 0);
        recv_col(32'hf20a225c, 0);
        sel_fwd = 1'b1;
        send_col(32'hdb135345, 0);
        recv_col(32'h8e4da1bc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
